uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side controller for the binary UART.
- Detects the start bit, times mid-bit sampling from a programmable baud divisor, and sequences the bit counter through start, 8 data bits and stop.
- Assembles the byte LSB-first and presents it on a valid/ready handshake.
- Sits between the rxd pin and the UART register/host interface. Replaces free-running baud_clk sequencing with a single-clock design that uses tick enables.

Parameters:
DATA_W, 8, data bits per frame
BAUD_W, 20, width of baud divisor (clk cycles per bit)
MIN_BAUD, 15, smallest legal divisor; below this the configuration is invalid

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  synchronous, active-low reset
sel  in  1  receiver enable; 0 = standby
baud  in  BAUD_W  clk cycles per bit period
rxd  in  1  asynchronous serial input, idle high
rx_ready  in  1  consumer accepts rx_data when high with rx_valid
rx_data  out  DATA_W  received byte, stable while rx_valid
rx_valid  out  1  byte available
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: frame completed while rx_valid=1 and rx_ready=0
cfg_err  out  1  level: sel=1 and baud < MIN_BAUD
busy  out  1  state != IDLE
bit_cnt  out  4  0=start, 1..8=data, 9=stop; 0 in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; all counters cleared; rx_data=0.
  - rx_valid, frame_err, overrun and busy are 0; sync flops are set to 1.
- cfg_err is combinational and is not affected by reset.
- rxd passes through a 2-flop synchronizer (rxd_s). Falling edge = previous rxd_s 1, current rxd_s 0.
- Baud down-counter (baud_cnt, BAUD_W bits):
  - tick when baud_cnt==0 in an active state, then reload baud_q-1.
  - baud_q is latched from baud on start detect; changing baud mid-frame has no effect.
- States:
  - IDLE: on a falling edge, with sel=1 and cfg_err=0, latch baud_q and load baud_cnt=(baud>>1)-1, then go to START.
  - START: on tick, sample rxd_s. If 0, go to DATA with bit_cnt=1. If 1 (glitch), go to IDLE with no flags raised.
  - DATA: on each tick, shift rxd_s into the MSB of shreg (right shift) and increment bit_cnt. After the sample at bit_cnt=8, go to STOP with bit_cnt=9.
  - STOP: on tick, sample rxd_s. If 1, complete the frame and go to IDLE. If 0, pulse frame_err, discard shreg and go to BREAK.
  - BREAK: stay until rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Frame completion and handshake:
  - If rx_valid=0, or rx_ready=1 in the same cycle: rx_data<=shreg and rx_valid<=1 in the next cycle.
  - Otherwise: pulse overrun, drop the new byte, keep the old rx_data.
- rx_valid clears on rx_valid&rx_ready when no completion happens in the same cycle.
- Latency: rx_valid rises 1 clk after the stop-bit sample cycle. The stop-bit sample is (baud>>1) + 9*baud clks after falling-edge detect.
- sel=0 or cfg_err=1 at any clk: state forced to IDLE and counters cleared.
  - rx_valid cleared only by sel=0.
  - No frame_err or overrun is raised.
- Reset mid-frame: state and counters are cleared at that edge and partial data is discarded.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, BREAK (3-bit)
  - constants MIN_BAUD=15, DATA_W=8, STOP_IDX=9
- Sub-module uart_baud_tick: loadable BAUD_W down-counter with load and reload values, en, and tick output. Shared with the future TX controller.

Test Plan:
- baud=16, send 0xA5 with 8N1 and rx_ready=0 → rx_valid rises 153 clks after falling-edge detect, rx_data=0xA5, frame_err=0. Set rx_ready=1 for 1 clk → rx_valid=0.
- Start bit low for 4 clks only, baud=16 → returns to IDLE, rx_valid/frame_err stay 0, busy pulses for 8 clks.
- Stop bit driven 0, data 0x3C → frame_err pulses for 1 clk, rx_valid stays 0, state stays in BREAK until rxd=1.
- Two frames 0x11 then 0x22 with rx_ready=0 throughout → overrun pulses once and rx_data stays 0x11. Repeat with rx_ready=1 on the completion cycle → rx_data=0x22, no overrun.
- baud=14, sel=1, toggle rxd → cfg_err=1, busy=0, no rx_valid. Then baud=15, send 0xFF → rx_data=0xFF.
- rst_n=0 for 1 clk at bit_cnt=4 of frame 0x5A → busy=0, bit_cnt=0, no rx_valid. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver state encoding and
// frame constants. Imported by uart_rx_ctrl and uart_baud_tick.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Receiver sequencing states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_e;

   localparam int         MIN_BAUD = 15;    // smallest legal clks-per-bit divisor
   localparam int         DATA_W   = 8;     // data bits per frame
   localparam logic [3:0] STOP_IDX = 4'd9;  // bit_cnt value while in the stop bit

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Loadable down-counter producing a one-cycle tick each time it reaches zero
// while enabled; it then reloads and keeps counting. Disabled => cleared.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   count enable (counter held at 0 when low)
//   load       in   load load_val this cycle (wins over en)
//   load_val   in   first-period value (e.g. half bit for mid-bit sampling)
//   reload_val in   value reloaded after every tick (bit period - 1)
//   tick       out  combinational tick: en & counter == 0
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int BAUD_W = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [BAUD_W-1:0] load_val,
   input  logic [BAUD_W-1:0] reload_val,
   output logic              tick
);
   import uart_pkg::*;

   logic [BAUD_W-1:0] cnt_q;
   logic [BAUD_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = reload_val;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign tick = en && !load && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// UART receive controller (8N1). Synchronises rxd, detects the start edge,
// samples each bit mid-period using a programmable divisor, assembles the byte
// LSB-first and offers it on a valid/ready handshake.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   sel        in   receiver enable (0 = standby, also drops rx_valid)
//   baud       in   clk cycles per bit, latched at start detect
//   rxd        in   asynchronous serial input, idle high
//   rx_ready   in   consumer accepts rx_data while rx_valid
//   rx_data    out  received byte, stable while rx_valid
//   rx_valid   out  byte available
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: byte dropped, previous one not taken
//   cfg_err    out  level: sel=1 with baud below MIN_BAUD
//   busy       out  receiver not idle
//   bit_cnt    out  0=start, 1..8=data, 9=stop; 0 when idle
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
   parameter int DATA_W   = uart_pkg::DATA_W,
   parameter int BAUD_W   = 20,
   parameter int MIN_BAUD = uart_pkg::MIN_BAUD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic [BAUD_W-1:0] baud,
   input  logic              rxd,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err,
   output logic              overrun,
   output logic              cfg_err,
   output logic              busy,
   output logic [3:0]        bit_cnt
);
   import uart_pkg::*;

   localparam logic [3:0] LAST_DATA = 4'(DATA_W);

   state_e            state_q;
   logic              sync1_q;
   logic              rxs_q;       // synchronised rxd
   logic              rxs_prev_q;  // rxs one cycle earlier, for edge detect
   logic [3:0]        bit_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic [BAUD_W-1:0] baud_q;
   logic [DATA_W-1:0] rx_data_q;
   logic              rx_valid_q;
   logic              frame_err_q;
   logic              overrun_q;

   logic              run_ok;
   logic              fall;
   logic              active;
   logic              ld;
   logic              tick;
   logic [BAUD_W-1:0] half_m1;
   logic [BAUD_W-1:0] full_m1;

   assign cfg_err = sel && (baud < BAUD_W'(MIN_BAUD));
   assign run_ok  = sel && !cfg_err;
   assign fall    = rxs_prev_q && !rxs_q;
   assign active  = (state_q == START) || (state_q == DATA) || (state_q == STOP);
   assign ld      = (state_q == IDLE) && run_ok && fall;

   // First wait is half a bit so every later tick lands mid-bit.
   assign half_m1 = (baud >> 1) - 1'b1;
   assign full_m1 = baud_q - 1'b1;

   uart_baud_tick #(
      .BAUD_W (BAUD_W)
   ) u_baud_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (run_ok && active),
      .load       (ld),
      .load_val   (half_m1),
      .reload_val (full_m1),
      .tick       (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         rxs_prev_q  <= 1'b1;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         baud_q      <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync1_q     <= rxd;
         rxs_q       <= sync1_q;
         rxs_prev_q  <= rxs_q;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;

         // Consumer take; a completion in the same cycle overrides this below.
         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end

         if (!run_ok) begin
            // Standby or bad divisor: abandon any frame silently.
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            if (!sel) begin
               rx_valid_q <= 1'b0;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (fall) begin
                     baud_q  <= baud;
                     state_q <= START;
                  end
               end
               START: begin
                  if (tick) begin
                     if (!rxs_q) begin
                        state_q   <= DATA;
                        bit_cnt_q <= 4'd1;
                     end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                     end
                  end
               end
               DATA: begin
                  if (tick) begin
                     shreg_q <= {rxs_q, shreg_q[DATA_W-1:1]};
                     if (bit_cnt_q == LAST_DATA) begin
                        state_q   <= STOP;
                        bit_cnt_q <= STOP_IDX;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                     end
                  end
               end
               STOP: begin
                  if (tick) begin
                     bit_cnt_q <= '0;
                     if (rxs_q) begin
                        state_q <= IDLE;
                        if (!rx_valid_q || rx_ready) begin
                           rx_data_q  <= shreg_q;
                           rx_valid_q <= 1'b1;
                        end else begin
                           overrun_q <= 1'b1;
                        end
                     end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                     end
                  end
               end
               BREAK: begin
                  // Wait for the line to return high so a held-low line
                  // cannot look like a fresh start bit.
                  if (rxs_q) begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q   <= IDLE;
                  bit_cnt_q <= '0;
               end
            endcase
         end
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl: directed scenarios followed by random
// frames compared against a frame-level reference model (expected byte, valid
// state, error pulses and start-to-valid latency).
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic [19:0] baud;
   logic        rxd;
   logic        rx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        overrun;
   logic        cfg_err;
   logic        busy;
   logic [3:0]  bit_cnt;

   int n_vec = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sel       (sel),
      .baud      (baud),
      .rxd       (rxd),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .cfg_err   (cfg_err),
      .busy      (busy),
      .bit_cnt   (bit_cnt)
   );

   // ---------------- event monitor ----------------
   int   cyc        = 0;
   int   fe_cnt     = 0;
   int   ov_cnt     = 0;
   int   busy_len   = 0;
   int   busy_rise  = -1;
   int   valid_rise = -1;
   logic busy_prev  = 1'b0;
   logic valid_prev = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (busy === 1'b1) busy_len++;
      if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
      if (rx_valid === 1'b1 && !valid_prev) valid_rise = cyc;
      busy_prev  = (busy === 1'b1);
      valid_prev = (rx_valid === 1'b1);
   end

   // ---------------- helpers ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_marks();
      busy_len   = 0;
      busy_rise  = -1;
      valid_rise = -1;
   endtask

   // Drive one frame, each bit held b clks. rxd is left at the stop value.
   // If rst_at >= 0, pulse reset for one clk once bit_cnt reaches rst_at and
   // abandon the rest of the frame.
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int b,
                             input int rst_at, output bit did_rst);
      logic [9:0] bits;
      bits    = {stop_v, d, 1'b0};
      did_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         for (int k = 0; k < b; k++) begin
            step(1);
            if (rst_at >= 0 && bit_cnt == 4'(rst_at)) begin
               rst_n = 1'b0;
               rxd   = 1'b1;
               step(1);
               check_val("rst_busy", 32'(busy), 32'd0);
               check_val("rst_bitcnt", 32'(bit_cnt), 32'd0);
               check_val("rst_valid", 32'(rx_valid), 32'd0);
               check_val("rst_data", 32'(rx_data), 32'd0);
               rst_n   = 1'b1;
               did_rst = 1'b1;
               return;
            end
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit         dr;
      int         fe0;
      int         ov0;
      int         b;
      logic [7:0] d;
      logic       stop_v;
      bit         pol;
      logic       mv;
      logic [7:0] md;
      bit         exp_fe;
      bit         exp_ov;
      bit         exp_rise;
      bit         seen;

      rxd      = 1'b1;
      sel      = 1'b1;
      baud     = 20'd16;
      rx_ready = 1'b0;
      rst_n    = 1'b0;
      step(3);
      check_val("reset_valid", 32'(rx_valid), 32'd0);
      check_val("reset_busy", 32'(busy), 32'd0);
      check_val("reset_bitcnt", 32'(bit_cnt), 32'd0);
      check_val("reset_data", 32'(rx_data), 32'd0);
      check_val("reset_fe", 32'(frame_err), 32'd0);
      check_val("reset_ov", 32'(overrun), 32'd0);
      check_val("reset_cfg", 32'(cfg_err), 32'd0);
      rst_n = 1'b1;
      step(3);

      // 1) 0xA5 at baud 16, consumer not ready
      clear_marks();
      fe0 = fe_cnt;
      send_frame(8'hA5, 1'b1, 16, -1, dr);
      rxd = 1'b1;
      step(8);
      $display("txn A5 baud=16: rx_data=%02h rx_valid=%0b", rx_data, rx_valid);
      // busy rises one clk after detect; valid 153 clks after detect
      check_val("t1_latency", 32'(valid_rise - busy_rise), 32'd152);
      check_val("t1_data", 32'(rx_data), 32'hA5);
      check_val("t1_valid", 32'(rx_valid), 32'd1);
      check_val("t1_fe", 32'(fe_cnt - fe0), 32'd0);
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
      check_val("t1_consume", 32'(rx_valid), 32'd0);

      // 2) glitch: start low for 4 clks only
      clear_marks();
      fe0 = fe_cnt;
      rxd = 1'b0;
      step(4);
      rxd = 1'b1;
      step(40);
      $display("txn glitch: busy_len=%0d", busy_len);
      check_val("t2_busy_len", 32'(busy_len), 32'd8);
      check_val("t2_valid", 32'(rx_valid), 32'd0);
      check_val("t2_fe", 32'(fe_cnt - fe0), 32'd0);

      // 3) stop bit low, line held low afterwards
      clear_marks();
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 16, -1, dr);
      step(48);
      $display("txn 3C bad stop: busy=%0b fe_pulses=%0d", busy, fe_cnt - fe0);
      check_val("t3_fe_once", 32'(fe_cnt - fe0), 32'd1);
      check_val("t3_valid", 32'(rx_valid), 32'd0);
      check_val("t3_break", 32'(busy), 32'd1);
      rxd = 1'b1;
      step(6);
      check_val("t3_release", 32'(busy), 32'd0);

      // 4a) two frames, consumer never ready
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1, 16, -1, dr);
      rxd = 1'b1;
      step(32);
      send_frame(8'h22, 1'b1, 16, -1, dr);
      rxd = 1'b1;
      step(16);
      $display("txn 11,22 no ready: rx_data=%02h overruns=%0d", rx_data, ov_cnt - ov0);
      check_val("t4_ov", 32'(ov_cnt - ov0), 32'd1);
      check_val("t4_data", 32'(rx_data), 32'h11);
      check_val("t4_valid", 32'(rx_valid), 32'd1);

      // 4b) ready only in the completion cycle
      ov0 = ov_cnt;
      fork
         begin
            send_frame(8'h22, 1'b1, 16, -1, dr);
            rxd = 1'b1;
         end
         begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
               step(1);
               seen = (busy === 1'b1);
            end
            if (!seen) check_val("t4_busy_timeout", 32'd0, 32'd1);
            else begin
               step(151);
               rx_ready = 1'b1;
               step(1);
               rx_ready = 1'b0;
            end
         end
      join
      step(8);
      $display("txn 22 ready-at-completion: rx_data=%02h", rx_data);
      check_val("t4b_ov", 32'(ov_cnt - ov0), 32'd0);
      check_val("t4b_data", 32'(rx_data), 32'h22);
      check_val("t4b_valid", 32'(rx_valid), 32'd1);

      // 5) sel=0 drops valid; baud below minimum; baud at minimum
      sel  = 1'b0;
      baud = 20'd14;
      step(1);
      check_val("t5_sel0_valid", 32'(rx_valid), 32'd0);
      check_val("t5_sel0_cfg", 32'(cfg_err), 32'd0);
      sel = 1'b1;
      step(1);
      check_val("t5_cfg", 32'(cfg_err), 32'd1);
      clear_marks();
      send_frame(8'h55, 1'b1, 16, -1, dr);
      rxd = 1'b1;
      step(16);
      $display("txn 55 baud=14: busy_len=%0d rx_valid=%0b", busy_len, rx_valid);
      check_val("t5_busy_len", 32'(busy_len), 32'd0);
      check_val("t5_valid", 32'(rx_valid), 32'd0);
      baud = 20'd15;
      step(1);
      check_val("t5_cfg_min", 32'(cfg_err), 32'd0);
      clear_marks();
      send_frame(8'hFF, 1'b1, 15, -1, dr);
      rxd = 1'b1;
      step(8);
      $display("txn FF baud=15: rx_data=%02h", rx_data);
      check_val("t5_data", 32'(rx_data), 32'hFF);
      check_val("t5_valid15", 32'(rx_valid), 32'd1);
      check_val("t5_latency", 32'(valid_rise - busy_rise), 32'(7 + 9 * 15));
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;

      // 6) reset mid-frame, then a clean frame
      baud = 20'd16;
      send_frame(8'h5A, 1'b1, 16, 4, dr);
      rxd = 1'b1;
      check_val("t6_rst_hit", 32'(dr), 32'd1);
      step(40);
      check_val("t6_idle", 32'(busy), 32'd0);
      check_val("t6_novalid", 32'(rx_valid), 32'd0);
      send_frame(8'h81, 1'b1, 16, -1, dr);
      rxd = 1'b1;
      step(8);
      $display("txn 81 after reset: rx_data=%02h", rx_data);
      check_val("t6_data", 32'(rx_data), 32'h81);
      check_val("t6_valid", 32'(rx_valid), 32'd1);

      // 7) random frames against the frame-level model
      mv = 1'b1;
      md = 8'h81;
      for (int n = 0; n < 12; n++) begin
         b        = int'($urandom_range(40, 15));
         d        = 8'($urandom_range(255, 0));
         stop_v   = ($urandom_range(3, 0) != 0);
         pol      = 1'($urandom_range(1, 0));
         baud     = 20'(b);
         rx_ready = pol;
         exp_fe   = 1'b0;
         exp_ov   = 1'b0;
         if (pol) mv = 1'b0;            // held-high ready takes any pending byte
         exp_rise = stop_v && !mv;
         if (!stop_v) exp_fe = 1'b1;
         else if (!mv) begin
            md = d;
            mv = !pol;
         end else exp_ov = 1'b1;
         fe0 = fe_cnt;
         ov0 = ov_cnt;
         step(2);
         clear_marks();
         send_frame(d, stop_v, b, -1, dr);
         rxd = 1'b1;
         step(b + int'($urandom_range(6, 1)));
         rx_ready = 1'b0;
         step(1);
         $display("txn rnd %0d: byte=%02h baud=%0d stop=%0b ready=%0b -> rx_data=%02h rx_valid=%0b",
                  n, d, b, stop_v, pol, rx_data, rx_valid);
         check_val("rnd_data", 32'(rx_data), 32'(md));
         check_val("rnd_valid", 32'(rx_valid), 32'(mv));
         check_val("rnd_fe", 32'(fe_cnt - fe0), 32'(exp_fe));
         check_val("rnd_ov", 32'(ov_cnt - ov0), 32'(exp_ov));
         if (exp_rise)
            check_val("rnd_latency", 32'(valid_rise - busy_rise), 32'((b >> 1) + 9 * b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
